// File: rtl/arcade_input_ctrl.sv
// Player-input conditioner: maps hps_io joystick words to per-player controls with coin pulse shaping.
// Optional autofire on button 0 is built when ARCADE_INPUT_AUTOFIRE_EN is defined.
module arcade_input_ctrl #(
  parameter int unsigned PLAYERS      = 2,
  parameter int unsigned BTNS         = 1,
  parameter int unsigned COIN_PULSE   = 16,
  parameter int unsigned AUTOFIRE_DIV = 200000
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic [16*PLAYERS-1:0]   joystick,
  input  logic                    merge_mode,
  input  logic                    cocktail_swap,
  input  logic                    coin_from_start,
  input  logic [PLAYERS-1:0]      autofire_en,
  output logic [4*PLAYERS-1:0]    dir,
  output logic [BTNS*PLAYERS-1:0] btn,
  output logic [PLAYERS-1:0]      start,
  output logic [PLAYERS-1:0]      coin
);

  localparam int unsigned CW = $clog2(COIN_PULSE + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(COIN_PULSE - 1);

  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_GAP} coin_state_e;

  logic [15:0] word [PLAYERS];
  logic [15:0] src  [PLAYERS];
  logic [15:0] merged;
  logic [PLAYERS-1:0] req;
  logic [PLAYERS-1:0] unused_hi;

  logic [4*PLAYERS-1:0]    dir_q,   dir_d;
  logic [BTNS*PLAYERS-1:0] btn_q,   btn_d;
  logic [PLAYERS-1:0]      start_q, start_d;
  logic [PLAYERS-1:0]      coin_q,  coin_d;
  logic [PLAYERS-1:0]      req_prev_q, req_prev_d;
  coin_state_e             state_q [PLAYERS];
  coin_state_e             state_d [PLAYERS];
  logic [CW-1:0]           cnt_q   [PLAYERS];
  logic [CW-1:0]           cnt_d   [PLAYERS];

  always_comb begin
    merged = '0;
    for (int unsigned i = 0; i < PLAYERS; i++) merged = merged | joystick[16*i +: 16];
  end

  // Swap only exists for players 0/1 and only when a second player is present.
  for (genvar n = 0; n < PLAYERS; n++) begin : g_src
    assign word[n] = joystick[16*n +: 16];
    if (PLAYERS > 1 && n < 2) begin : g_sw
      assign src[n] = merge_mode ? merged : (cocktail_swap ? word[1-n] : word[n]);
    end else begin : g_ns
      assign src[n] = merge_mode ? merged : word[n];
    end
    assign unused_hi[n] = ^src[n][15:6+BTNS];
  end

`ifdef ARCADE_INPUT_AUTOFIRE_EN
  localparam int unsigned AFW = $clog2(AUTOFIRE_DIV);
  localparam logic [AFW-1:0] AF_MAX = AFW'(AUTOFIRE_DIV - 1);

  logic [AFW-1:0] af_cnt_q, af_cnt_d;
  logic           phase_q,  phase_d;

  always_comb begin
    af_cnt_d = af_cnt_q + 1'b1;
    phase_d  = phase_q;
    if (af_cnt_q == AF_MAX) begin
      af_cnt_d = '0;
      phase_d  = ~phase_q;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      af_cnt_q <= '0;
      phase_q  <= 1'b1;
    end else begin
      af_cnt_q <= af_cnt_d;
      phase_q  <= phase_d;
    end
  end
`else
  logic unused_af;
  assign unused_af = ^autofire_en;
`endif

  always_comb begin
    dir_d      = '0;
    btn_d      = '0;
    start_d    = '0;
    req        = '0;
    coin_d     = coin_q;
    req_prev_d = req_prev_q;
    for (int unsigned n = 0; n < PLAYERS; n++) begin
      state_d[n] = state_q[n];
      cnt_d[n]   = cnt_q[n];

      dir_d[4*n +: 4] = {src[n][3] & ~src[n][2], src[n][2] & ~src[n][3],
                         src[n][1] & ~src[n][0], src[n][0] & ~src[n][1]};
      btn_d[BTNS*n +: BTNS] = src[n][4 +: BTNS];
`ifdef ARCADE_INPUT_AUTOFIRE_EN
      if (autofire_en[n]) btn_d[BTNS*n] = src[n][4] & phase_q;
`endif
      start_d[n] = src[n][4+BTNS];

      req[n]        = src[n][5+BTNS] | (coin_from_start & src[n][4+BTNS]);
      req_prev_d[n] = req[n];

      // Edges seen outside IDLE are intentionally lost rather than queued.
      case (state_q[n])
        S_IDLE: begin
          if (req[n] && !req_prev_q[n]) begin
            state_d[n] = S_PULSE;
            cnt_d[n]   = CNT_LOAD;
            coin_d[n]  = 1'b1;
          end
        end
        S_PULSE: begin
          if (cnt_q[n] == '0) begin
            state_d[n] = S_GAP;
            cnt_d[n]   = CNT_LOAD;
            coin_d[n]  = 1'b0;
          end else begin
            cnt_d[n] = cnt_q[n] - 1'b1;
          end
        end
        S_GAP: begin
          if (cnt_q[n] == '0) state_d[n] = S_IDLE;
          else                cnt_d[n]   = cnt_q[n] - 1'b1;
        end
        default: begin
          state_d[n] = S_IDLE;
          cnt_d[n]   = '0;
          coin_d[n]  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dir_q      <= '0;
      btn_q      <= '0;
      start_q    <= '0;
      coin_q     <= '0;
      req_prev_q <= '1;
      for (int unsigned n = 0; n < PLAYERS; n++) begin
        state_q[n] <= S_IDLE;
        cnt_q[n]   <= '0;
      end
    end else begin
      dir_q      <= dir_d;
      btn_q      <= btn_d;
      start_q    <= start_d;
      coin_q     <= coin_d;
      req_prev_q <= req_prev_d;
      for (int unsigned n = 0; n < PLAYERS; n++) begin
        state_q[n] <= state_d[n];
        cnt_q[n]   <= cnt_d[n];
      end
    end
  end

  assign dir   = dir_q;
  assign btn   = btn_q;
  assign start = start_q;
  assign coin  = coin_q;

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Directed bench for arcade_input_ctrl (PLAYERS=2, BTNS=1, COIN_PULSE=16, AUTOFIRE_DIV=4).
module tb_arcade_input_ctrl;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [31:0] joystick;
  logic        merge_mode;
  logic        cocktail_swap;
  logic        coin_from_start;
  logic [1:0]  autofire_en;
  logic [7:0]  dir;
  logic [1:0]  btn;
  logic [1:0]  start;
  logic [1:0]  coin;

  int checks = 0;
  int errors = 0;

  arcade_input_ctrl #(
    .PLAYERS(2),
    .BTNS(1),
    .COIN_PULSE(16),
    .AUTOFIRE_DIV(4)
  ) dut (
    .clk_sys(clk_sys),
    .reset(reset),
    .joystick(joystick),
    .merge_mode(merge_mode),
    .cocktail_swap(cocktail_swap),
    .coin_from_start(coin_from_start),
    .autofire_en(autofire_en),
    .dir(dir),
    .btn(btn),
    .start(start),
    .coin(coin)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic step(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic measure(input int n, input int idx, output int highs, output int rises);
    logic prev;
    prev  = coin[idx];
    highs = 0;
    rises = 0;
    repeat (n) begin
      step(1);
      if (coin[idx]) highs++;
      if (coin[idx] && !prev) rises++;
      prev = coin[idx];
    end
  endtask

  initial begin
    int hi, ri;
    logic [15:0] af;

    reset = 1'b1; joystick = '0; merge_mode = 1'b0; cocktail_swap = 1'b0;
    coin_from_start = 1'b0; autofire_en = '0;
    step(2);
    check("reset_dir", dir, 0);
    check("reset_btn", btn, 0);
    check("reset_start", start, 0);
    check("reset_coin", coin, 0);
    reset = 1'b0;
    step(1);
    check("idle_coin", coin, 0);

    // Direction mapping and cleaning on P1
    joystick = 32'h0000_0001; step(1); check("dir_right", dir, 8'h01);
    joystick = 32'h0000_0003; step(1); check("dir_lr_clean", dir, 8'h00);
    joystick = 32'h0000_000C; step(1); check("dir_ud_clean", dir, 8'h00);
    joystick = 32'h0000_0005; step(1); check("dir_down_right", dir, 8'h05);
    joystick = 32'h0000_000A; step(1); check("dir_up_left", dir, 8'h0A);
    joystick = 32'h0000_000F; step(1); check("dir_all_clean", dir, 8'h00);
    joystick = '0; step(2);

    // P2 coin held for 100 cycles
    joystick = 32'h0040_0000;
    measure(100, 1, hi, ri);
    check("coin_held_high", hi, 16);
    check("coin_held_rises", ri, 1);
    check("coin_held_p1", coin[0], 0);
    joystick = '0; step(40);

    // Presses at 0, 20 (inside GAP) and 40
    hi = 0; ri = 0;
    begin
      logic prev;
      prev = coin[1];
      for (int k = 0; k < 70; k++) begin
        if (k == 0 || k == 20 || k == 40) joystick = 32'h0040_0000;
        if (k == 2 || k == 22 || k == 42) joystick = '0;
        step(1);
        if (coin[1]) hi++;
        if (coin[1] && !prev) ri++;
        prev = coin[1];
      end
    end
    check("coin_gap_high", hi, 32);
    check("coin_gap_rises", ri, 2);
    step(20);

    // Merge and cocktail swap
    merge_mode = 1'b1; joystick = 32'h0010_0000; step(1);
    check("merge_btn", btn, 2'b11);
    merge_mode = 1'b0; cocktail_swap = 1'b1; step(1);
    check("swap_btn", btn, 2'b01);
    joystick = 32'h0010_0001; step(1);
    check("swap_dir", dir, 8'h10);
    merge_mode = 1'b1; step(1);
    check("merge_over_swap_dir", dir, 8'h11);
    merge_mode = 1'b0; cocktail_swap = 1'b0; joystick = '0; step(2);

    // Coin derived from start
    coin_from_start = 1'b1; joystick = 32'h0000_0020; step(1);
    check("cfs_start", start, 2'b01);
    check("cfs_coin_latency", coin, 2'b01);
    measure(40, 0, hi, ri);
    check("cfs_coin_high", hi, 15);
    joystick = '0; step(40);
    coin_from_start = 1'b0; joystick = 32'h0000_0020;
    measure(40, 0, hi, ri);
    check("nocfs_start", start, 2'b01);
    check("nocfs_coin_high", hi, 0);
    joystick = '0; step(2);

    // Autofire on P1 button 0, starting from reset
    autofire_en = 2'b01; joystick = 32'h0000_0010; reset = 1'b1;
    step(2);
    reset = 1'b0;
    af = '0;
    for (int i = 0; i < 16; i++) begin
      step(1);
      af[i] = btn[0];
    end
`ifdef ARCADE_INPUT_AUTOFIRE_EN
    check("autofire_pattern", af, 16'h0F0F);
`else
    check("autofire_pattern", af, 16'hFFFF);
`endif
    check("autofire_p2_btn", btn[1], 0);
    autofire_en = '0; joystick = '0; step(2);

    // Coin held through reset release
    reset = 1'b1; joystick = 32'h0040_0000; step(2);
    reset = 1'b0;
    measure(40, 1, hi, ri);
    check("coin_thru_reset", hi, 0);
    joystick = '0; step(2);

    // Reset in the middle of a pulse
    joystick = 32'h0040_0000; step(5);
    check("midpulse_high", coin[1], 1);
    reset = 1'b1; #1;
    check("midpulse_async_drop", coin, 0);
    step(1);
    reset = 1'b0; joystick = '0; step(2);
    joystick = 32'h0040_0000;
    measure(40, 1, hi, ri);
    check("post_reset_high", hi, 16);
    check("post_reset_rises", ri, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
